// File: rtl/seq_det_event_logger.sv
// -----------------------------------------------------------------------------
// seq_det_event_logger
//
// Timestamps every detection reported by an upstream 3-ones Mealy recognizer
// and queues the timestamps in a small FIFO for a downstream consumer.
//
// A session runs while en=1. The timestamp counts enabled cycles from 0 and
// restarts at 0 after any cycle with en=0. Each enabled cycle with det_in=1
// is one event; the timestamp of that cycle (before its increment) is pushed.
//
// Ports
//   clk        in   1            rising-edge clock
//   rst_n      in   1            asynchronous active-low reset
//   en         in   1            session enable (shared with the recognizer)
//   det_in     in   1            recognizer detection, sampled at the edge
//   clr        in   1            synchronous clear of all logger state
//   evt_valid  out  1            head event available
//   evt_ready  in   1            consumer accepts the head event
//   evt_ts     out  TS_W         head event timestamp (0 while empty)
//   evt_count  out  CNT_W        saturating count of all detections
//   fifo_level out  log2(DEPTH)+1 number of stored events
//   overflow   out  1            sticky: an event was dropped on a full FIFO
// -----------------------------------------------------------------------------
module seq_det_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       det_in,
  input  logic                       clr,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [TS_W-1:0]            evt_ts,
  output logic [CNT_W-1:0]           evt_count,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0]    LVL_ONE  = LW'(1'b1);
  localparam logic [LW-1:0]    LVL_ZERO = {LW{1'b0}};
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1'b1);
  localparam logic [AW-1:0]    PTR_ZERO = {AW{1'b0}};
  localparam logic [TS_W-1:0]  TS_ONE   = TS_W'(1'b1);
  localparam logic [TS_W-1:0]  TS_ZERO  = {TS_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // State registers
  logic [TS_W-1:0]  ts_q,         ts_d;
  logic [AW-1:0]    wr_ptr_q,     wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q,     rd_ptr_d;
  logic [LW-1:0]    fifo_level_q, fifo_level_d;
  logic [CNT_W-1:0] evt_count_q,  evt_count_d;
  logic             overflow_q,   overflow_d;
  logic             evt_valid_q,  evt_valid_d;
  logic [TS_W-1:0]  evt_ts_q,     evt_ts_d;
  logic [TS_W-1:0]  mem_q [DEPTH];
  logic [TS_W-1:0]  mem_d [DEPTH];

  // Per-cycle handshake decodes
  logic push_s;
  logic pop_s;
  logic full_s;
  logic accept_s;

  // Next-state logic for timestamp, FIFO, counter and flags
  always_comb begin
    ts_d         = ts_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_level_d = fifo_level_q;
    evt_count_d  = evt_count_q;
    overflow_d   = overflow_q;
    mem_d        = mem_q;
    accept_s     = 1'b0;

    push_s = en & det_in;
    // evt_valid_q is exactly "FIFO not empty", so evt_ready is ignored when empty
    pop_s  = evt_valid_q & evt_ready;
    full_s = (fifo_level_q == LVL_FULL);

    if (clr) begin
      // clr wins over any same-cycle push or pop
      ts_d         = TS_ZERO;
      wr_ptr_d     = PTR_ZERO;
      rd_ptr_d     = PTR_ZERO;
      fifo_level_d = LVL_ZERO;
      evt_count_d  = CNT_ZERO;
      overflow_d   = 1'b0;
    end else begin
      if (en) begin
        ts_d = ts_q + TS_ONE;
      end else begin
        ts_d = TS_ZERO;
      end

      // Dropped events still count
      if (push_s && (evt_count_q != CNT_MAX)) begin
        evt_count_d = evt_count_q + CNT_ONE;
      end else begin
        evt_count_d = evt_count_q;
      end

      // A full FIFO still accepts a push when the head leaves in the same cycle
      if (push_s && full_s && !pop_s) begin
        accept_s   = 1'b0;
        overflow_d = 1'b1;
      end else begin
        accept_s   = push_s;
        overflow_d = overflow_q;
      end

      if (accept_s) begin
        mem_d[wr_ptr_q] = ts_q;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({accept_s, pop_s})
        2'b10:   fifo_level_d = fifo_level_q + LVL_ONE;
        2'b01:   fifo_level_d = fifo_level_q - LVL_ONE;
        default: fifo_level_d = fifo_level_q;
      endcase
    end

    // Head outputs are registered from the next-state view of the FIFO so a
    // push into an empty FIFO shows up one cycle after the event edge.
    evt_valid_d = (fifo_level_d != LVL_ZERO);
    if (evt_valid_d) begin
      evt_ts_d = mem_d[rd_ptr_d];
    end else begin
      evt_ts_d = TS_ZERO;
    end
  end

  // State update; reset clears everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q         <= TS_ZERO;
      wr_ptr_q     <= PTR_ZERO;
      rd_ptr_q     <= PTR_ZERO;
      fifo_level_q <= LVL_ZERO;
      evt_count_q  <= CNT_ZERO;
      overflow_q   <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_ts_q     <= TS_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= TS_ZERO;
      end
    end else begin
      ts_q         <= ts_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_level_q <= fifo_level_d;
      evt_count_q  <= evt_count_d;
      overflow_q   <= overflow_d;
      evt_valid_q  <= evt_valid_d;
      evt_ts_q     <= evt_ts_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_ts     = evt_ts_q;
  assign evt_count  = evt_count_q;
  assign fifo_level = fifo_level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_seq_det_event_logger.sv
// -----------------------------------------------------------------------------
// tb_seq_det_event_logger
//
// Directed bench for seq_det_event_logger (TS_W=4, DEPTH=4, CNT_W=8).
// A queue holds the timestamps expected in the FIFO: pushed as events are
// driven, popped when the consumer handshake takes the head.
// -----------------------------------------------------------------------------
module tb_seq_det_event_logger;

  localparam int TS_W  = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             det_in;
  logic             clr;
  logic             evt_valid;
  logic             evt_ready;
  logic [TS_W-1:0]  evt_ts;
  logic [CNT_W-1:0] evt_count;
  logic [2:0]       fifo_level;
  logic             overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [TS_W-1:0]  exp_q[$];
  logic [TS_W-1:0]  m_ts;
  logic [CNT_W-1:0] m_cnt;
  logic             m_ovf;

  seq_det_event_logger #(
    .TS_W (TS_W),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .det_in    (det_in),
    .clr       (clr),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ts    (evt_ts),
    .evt_count (evt_count),
    .fifo_level(fifo_level),
    .overflow  (overflow)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [TS_W-1:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 4'd0;
    chk({tag, ".valid"}, 32'(evt_valid),  32'(exp_q.size() != 0));
    chk({tag, ".ts"},    32'(evt_ts),     32'(head));
    chk({tag, ".level"}, 32'(fifo_level), 32'(exp_q.size()));
    chk({tag, ".count"}, 32'(evt_count),  32'(m_cnt));
    chk({tag, ".ovf"},   32'(overflow),   32'(m_ovf));
  endtask

  // One clock cycle: drive inputs, advance the reference, check after the edge
  task automatic step(input string tag, input logic e, input logic d,
                      input logic r, input logic c);
    logic push;
    logic pop;
    en = e; det_in = d; evt_ready = r; clr = c;
    pop  = (exp_q.size() != 0) && r;
    push = e && d;
    if (c) begin
      exp_q.delete();
      m_ts  = 4'd0;
      m_cnt = 8'd0;
      m_ovf = 1'b0;
    end else begin
      if (push && (m_cnt != 8'hFF)) m_cnt = m_cnt + 8'd1;
      if (pop) begin
        chk({tag, ".pop"}, 32'(evt_ts), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(m_ts);
        else m_ovf = 1'b1;
      end
      m_ts = e ? m_ts + 4'd1 : 4'd0;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [TS_W-1:0] drain_exp [4];

    rst_n = 1'b0; en = 1'b0; det_in = 1'b0; clr = 1'b0; evt_ready = 1'b0;
    m_ts = 4'd0; m_cnt = 8'd0; m_ovf = 1'b0;
    @(posedge clk); #1;
    check_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic events at cycles 2 and 5 with a glitch on det_in that must be ignored
    det_in = 1'b1; #2; det_in = 1'b0;
    step("basic0", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("glitch.level", 32'(fifo_level), 32'd0);
    step("basic1", 1'b1, 1'b0, 1'b1, 1'b0);
    step("basic2", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("basic.ts2", 32'(evt_ts), 32'd2);
    chk("basic.v2", 32'(evt_valid), 32'd1);
    step("basic3", 1'b1, 1'b0, 1'b1, 1'b0);
    step("basic4", 1'b1, 1'b0, 1'b1, 1'b0);
    step("basic5", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("basic.ts5", 32'(evt_ts), 32'd5);
    step("basic6", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("basic.count", 32'(evt_count), 32'd2);
    chk("basic.empty", 32'(evt_valid), 32'd0);

    // Overflow: events at 1,3,5,7,9 with no consumer
    step("ovf.clr", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step("ovf", 1'b1, logic'(i % 2 == 1), 1'b0, 1'b0);
    end
    chk("ovf.level", 32'(fifo_level), 32'd4);
    chk("ovf.flag", 32'(overflow), 32'd1);
    chk("ovf.count", 32'(evt_count), 32'd5);
    drain_exp[0] = 4'd1; drain_exp[1] = 4'd3; drain_exp[2] = 4'd5; drain_exp[3] = 4'd7;
    for (int i = 0; i < 4; i++) begin
      chk("ovf.drain", 32'(evt_ts), 32'(drain_exp[i]));
      step("ovf.drain", 1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("ovf.sticky", 32'(overflow), 32'd1);

    // Wrap: en=0 above forced ts to 0; detection at enabled cycle 16 -> ts 0
    for (int i = 0; i < 16; i++) begin
      step("wrap", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step("wrap16", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("wrap.valid", 32'(evt_valid), 32'd1);
    chk("wrap.ts", 32'(evt_ts), 32'd0);
    // clr beats a same-cycle event
    step("clr.evt", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr.level", 32'(fifo_level), 32'd0);
    chk("clr.count", 32'(evt_count), 32'd0);
    chk("clr.ovf", 32'(overflow), 32'd0);

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < 4; i++) begin
      step("full", 1'b1, 1'b1, 1'b0, 1'b0);
    end
    step("full.pp", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("full.level", 32'(fifo_level), 32'd4);
    chk("full.ovf", 32'(overflow), 32'd0);
    chk("full.head", 32'(evt_ts), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step("full.drain", 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // Session break: en=0 with det_in=1 is ignored, queue kept, ts restarts
    step("sess.clr", 1'b1, 1'b0, 1'b0, 1'b1);
    step("sess0", 1'b1, 1'b0, 1'b0, 1'b0);
    step("sess1", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("sess.off", 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("sess.kept", 32'(fifo_level), 32'd1);
    chk("sess.count", 32'(evt_count), 32'd1);
    step("sess.on0", 1'b1, 1'b0, 1'b0, 1'b0);
    step("sess.on1", 1'b1, 1'b0, 1'b0, 1'b0);
    step("sess.on2", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sess.head", 32'(evt_ts), 32'd1);
    step("sess.pop", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("sess.ts2", 32'(evt_ts), 32'd2);
    step("sess.pop2", 1'b1, 1'b0, 1'b1, 1'b0);

    // Counter saturation with a streaming consumer
    step("sat.clr", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 260; i++) begin
      step("sat", 1'b1, 1'b1, 1'b1, 1'b0);
    end
    chk("sat.count", 32'(evt_count), 32'd255);

    // Asynchronous reset with three events queued
    step("rst.clr", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("rst.fill", 1'b1, 1'b1, 1'b0, 1'b0);
    end
    chk("rst.pre", 32'(fifo_level), 32'd3);
    en = 1'b0; det_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete(); m_ts = 4'd0; m_cnt = 8'd0; m_ovf = 1'b0;
    check_outputs("rst.async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_outputs("rst.hold");
    step("rst.first", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst.first.ts", 32'(evt_ts), 32'd0);
    chk("rst.first.lvl", 32'(fifo_level), 32'd1);
    step("rst.next", 1'b1, 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_det_event_logger.md
SEQ_DET_EVENT_LOGGER -- requirements
Module: seq_det_event_logger

Interface
REQ-001 SHALL have parameter TS_W, default 16, timestamp width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, event FIFO depth; power of two, at least 2.
REQ-003 SHALL have parameter CNT_W, default 8, detection counter width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  session enable, the same signal that drives the upstream 3-ones recognizer.
REQ-007 SHALL have port det_in  input  1  detection output of the upstream Mealy recognizer.
REQ-008 SHALL have port clr  input  1  synchronous clear of all logger state.
REQ-009 SHALL have port evt_valid  output  1  FIFO head event available.
REQ-010 SHALL have port evt_ready  input  1  consumer accepts head event.
REQ-011 SHALL have port evt_ts  output  TS_W  timestamp of the head event.
REQ-012 SHALL have port evt_count  output  CNT_W  total detections seen since reset or clr.
REQ-013 SHALL have port fifo_level  output  log2(DEPTH)+1  number of stored events.
REQ-014 SHALL have port overflow  output  1  sticky flag for a dropped event.

Function
REQ-015 SHALL keep timestamp ts: +1 each cycle with en=1; wraps from 2^TS_W-1 to 0; forced to 0 in any cycle with en=0 (new session).
REQ-016 SHALL sample det_in only at the clock edge and ignore combinational glitches between edges.
REQ-017 SHALL treat each cycle with en=1 and det_in=1 as one event; consecutive high cycles are separate events (e.g. ones run of 4 gives 2 events).
REQ-018 SHALL ignore det_in while en=0.
REQ-019 SHALL push the pre-increment ts value of the event cycle into the FIFO.
REQ-020 SHALL raise evt_valid in the cycle after the event edge when the FIFO was empty (1-cycle latency).
REQ-021 SHALL pop on a clock edge where evt_valid=1 and evt_ready=1.
REQ-022 SHALL hold evt_valid and evt_ts stable while evt_valid=1 and evt_ready=0.
REQ-023 SHALL drive evt_ts=0 while the FIFO is empty.
REQ-024 SHALL deliver events in arrival order (first-in first-out).
REQ-025 SHALL on push while full without pop: drop the event, keep FIFO contents, set overflow=1.
REQ-026 SHALL on push and pop in the same cycle while full: accept both, fifo_level stays DEPTH, overflow unchanged.
REQ-027 SHALL on push and pop in the same cycle while partially filled: leave fifo_level unchanged.
REQ-028 SHALL ignore evt_ready while the FIFO is empty.
REQ-029 SHALL increment evt_count on every event, including dropped events; saturates at 2^CNT_W-1.
REQ-030 SHALL keep overflow at 1 until reset or clr.
REQ-031 SHALL keep FIFO contents, evt_count and overflow when en falls; only ts is forced to 0.
REQ-032 SHALL on clr=1: empty the FIFO, zero ts, evt_count and overflow at the next edge.
REQ-033 SHALL give clr priority over a same-cycle push or pop.

Reset
REQ-034 SHALL on rst_n=0, immediately and independent of clk: evt_valid=0, evt_ts=0, evt_count=0, fifo_level=0, overflow=0, ts=0, pointers=0.
REQ-035 SHALL accept the first event on the first rising edge after rst_n deasserts.
REQ-036 SHALL discard the FIFO contents when reset asserts mid-operation, with no partial output.

Verification
REQ-037 SHALL cover reset: assert rst_n mid-stream with 3 events queued -> all outputs 0 at once, clean restart afterwards.
REQ-038 SHALL cover basic events: en=1 from cycle 0, det_in=1 at cycles 2 and 5, evt_ready=1 -> events ts=2 then ts=5, each valid 1 cycle after detection, evt_count=2.
REQ-039 SHALL cover overflow: evt_ready=0, DEPTH=4, det_in=1 at cycles 1,3,5,7,9 -> fifo_level=4, overflow=1, evt_count=5; draining gives ts 1,3,5,7.
REQ-040 SHALL cover full push+pop: FIFO full, event and evt_ready=1 in the same cycle -> fifo_level stays 4, overflow=0, new ts enters at the tail.
REQ-041 SHALL cover session break: en=0 for 3 cycles with det_in=1 -> no events, queued events kept; en=1 again with detection 2 cycles later -> ts=2.
REQ-042 SHALL cover wrap and clr: TS_W=4, detection at en cycle 16 -> ts=0; then clr together with an event -> FIFO empty, evt_count=0, overflow=0.
